ascon_serial_if: RTL and testbench
==================================

// Module: ascon_serial_if
// PURPOSE
//  Chip-side bit-serial front end for the ASCON AEAD core. Sits between the user GPIO pins and the core.
//  Deserialises key, nonce, AD and data (PT or CT) MSB-first, starts the core on the start pin, then
//  serialises the core result and tag back out LSB-first. It is the responder end of the host GPIO protocol.
// PARAMETERS
//  K         128  key width (bits)
//  L         40   associated-data width (bits)
//  Y         104  plaintext/ciphertext width (bits)
//  OUT_DLY   2    clocks from ready_so rise to first output bit
//  MAX       max(K,Y,L,128)  load/shift length (derived localparam, not overridable)
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    asynchronous active-low reset
//  key_si         in   1    serial key bit
//  nonce_si       in   1    serial nonce bit
//  ad_si          in   1    serial associated-data bit
//  data_si        in   1    serial PT (encrypt) / CT (decrypt) bit
//  start_si       in   1    start request (level, host holds >=1 clk)
//  decrypt_si     in   1    1 = decrypt, 0 = encrypt
//  data_so        out  1    serial result bit (CT or PT)
//  tag_so         out  1    serial tag bit
//  ready_so       out  1    result available
//  core_start     out  1    one-cycle start pulse to core
//  core_decrypt   out  1    mode latched at start
//  core_key       out  K    parallel key
//  core_nonce     out  128  parallel nonce
//  core_ad        out  L    parallel AD
//  core_din       out  Y    parallel PT/CT
//  core_dout      in   Y    core result
//  core_tag       in   128  core tag
//  core_done      in   1    one-cycle completion strobe from core
// BEHAVIOUR
//  - Reset (async): all outputs and registers 0, state LOAD, bit counter 0.
//  - LOAD: on each rising clk, cnt=0..MAX-1. Shift key_si into key reg if cnt<K, nonce_si if cnt<128,
//    ad_si if cnt<L, data_si if cnt<Y. First bit received becomes the MSB. After cnt=MAX-1 -> ARMED.
//    core_* parallel outputs are driven directly from the shift regs (valid from ARMED onward).
//  - ARMED: rising edge of start_si (registered prev=0, now=1) -> latch decrypt_si into core_decrypt,
//    assert core_start for exactly 1 clk, go to RUN. A start_si level held from LOAD gives no edge
//    while in ARMED and is ignored. start edges in LOAD, RUN, DELAY, SHIFT or DONE are ignored.
//  - RUN: wait for core_done; on it latch core_dout/core_tag into output shift regs, set ready_so the
//    next clk, go to DELAY. core_done in any other state is ignored.
//  - DELAY: count OUT_DLY clks, then SHIFT with cnt=0.
//  - SHIFT: for cnt=0..MAX-1, data_so = dout[cnt] if cnt<Y else 0; tag_so = tag[cnt] if cnt<128 else 0.
//    Bits are registered and change just after the rising clk, so the host samples on the next rising clk.
//    After MAX bits -> DONE; data_so/tag_so = 0.
//  - DONE: ready_so stays 1; only reset leaves DONE. A new operation always starts with rst_n.
//  - rst_n asserted mid-operation (any state) aborts immediately; core_start is never left high.
//  - cnt width = $clog2(MAX+1); no wrap-around is possible in either LOAD or SHIFT.
// STRUCTURE
//  - ascon_if_pkg: default widths K/L/Y, nonce width 128, state encoding (LOAD, ARMED, RUN, DELAY,
//    SHIFT, DONE).
//  - Sub-module ascon_shift_reg #(W): serial-in/parallel-out with shift enable, plus parallel-load
//    and bit-select read. Instantiated for key, nonce, ad, din, dout and tag.
// TESTING (core replaced by a model: done is asserted 20 clks after start with fixed dout/tag)
//  1. Load KEY=6d4f8bbf60ec05a07b201d4e5b2119ac, NONCE=05885e606e1271b8d47a74c7b297a318,
//     AD=4153434f4e, PT=6173636f6e2d756e6963617373 for 128 clks -> core_* equal these values exactly.
//  2. ARMED, start_si high 2 clks, decrypt_si=0 -> exactly one core_start pulse; core_decrypt=0.
//  3. Model returns dout=18490112f8d5867a830748390b -> ready_so=1 one clk after core_done; after 2 clks
//     data_so at bit i = dout[i] for i<104, then 0 to bit 127; tag_so carries all 128 tag bits LSB-first.
//  4. start_si edge at LOAD cnt=50 -> no core_start; load completes normally to ARMED.
//  5. rst_n low during SHIFT cnt=30 -> all outputs 0 at once. Then decrypt run with data=CT above and
//     decrypt_si=1 -> core_decrypt=1, core_din=CT.
//  6. core_done pulsed while in ARMED -> ready_so stays 0; state stays ARMED.

Source files
------------

// File: rtl/ascon_if_pkg.sv
// Shared widths and FSM encoding for the ASCON bit-serial GPIO front end.
package ascon_if_pkg;

    localparam int KEY_W       = 128;
    localparam int AD_W        = 40;
    localparam int DATA_W      = 104;
    localparam int NONCE_W     = 128;
    localparam int OUT_DLY_DEF = 2;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ARMED,
        ST_RUN,
        ST_DELAY,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ascon_shift_reg.sv
// Serial-in/parallel-out register with parallel load and single-bit read port.
module ascon_shift_reg #(
    parameter int W  = 8,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          shift_en,
    input  logic          sin,
    input  logic          load_en,
    input  logic [W-1:0]  load_val,
    input  logic [SW-1:0] sel,
    output logic [W-1:0]  q,
    output logic          bit_o
);

    logic [W-1:0] r;
    logic [W-1:0] one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (load_en) begin
            r <= load_val;
        end else if (shift_en) begin
            r <= {r[W-2:0], sin};
        end
    end

    // An out-of-range select shifts the marker out entirely, so the read returns 0.
    assign one_hot = {{(W-1){1'b0}}, 1'b1} << sel;
    assign bit_o   = |(r & one_hot);
    assign q       = r;

endmodule

// File: rtl/ascon_serial_if.sv
// GPIO-side responder: deserialises operands MSB-first, kicks the ASCON core, streams result/tag LSB-first.
module ascon_serial_if
    import ascon_if_pkg::*;
#(
    parameter int K       = KEY_W,
    parameter int L       = AD_W,
    parameter int Y       = DATA_W,
    parameter int OUT_DLY = OUT_DLY_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_si,
    input  logic               nonce_si,
    input  logic               ad_si,
    input  logic               data_si,
    input  logic               start_si,
    input  logic               decrypt_si,
    output logic               data_so,
    output logic               tag_so,
    output logic               ready_so,
    output logic               core_start,
    output logic               core_decrypt,
    output logic [K-1:0]       core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [L-1:0]       core_ad,
    output logic [Y-1:0]       core_din,
    input  logic [Y-1:0]       core_dout,
    input  logic [NONCE_W-1:0] core_tag,
    input  logic               core_done
);

    localparam int MAX = max4(K, Y, L, NONCE_W);
    localparam int CW  = $clog2(MAX + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] out_sel;
    logic          start_q;
    logic          in_load;
    logic          res_load;
    logic          dout_bit;
    logic          tag_bit;

    logic          unused_key_bit;
    logic          unused_nonce_bit;
    logic          unused_ad_bit;
    logic          unused_din_bit;
    logic [Y-1:0]       unused_dout_q;
    logic [NONCE_W-1:0] unused_tag_q;

    assign in_load  = (state == ST_LOAD);
    assign res_load = (state == ST_RUN) && core_done;

    // The output bit registered at each edge is the one for the slot being entered.
    assign out_sel  = (state == ST_SHIFT) ? cnt + CW'(1) : '0;

    ascon_shift_reg #(.W(K), .SW(CW)) u_key (
        .clk(clk), .rst_n(rst_n),
        .shift_en(in_load && (cnt < CW'(K))), .sin(key_si),
        .load_en(1'b0), .load_val('0), .sel('0),
        .q(core_key), .bit_o(unused_key_bit)
    );

    ascon_shift_reg #(.W(NONCE_W), .SW(CW)) u_nonce (
        .clk(clk), .rst_n(rst_n),
        .shift_en(in_load && (cnt < CW'(NONCE_W))), .sin(nonce_si),
        .load_en(1'b0), .load_val('0), .sel('0),
        .q(core_nonce), .bit_o(unused_nonce_bit)
    );

    ascon_shift_reg #(.W(L), .SW(CW)) u_ad (
        .clk(clk), .rst_n(rst_n),
        .shift_en(in_load && (cnt < CW'(L))), .sin(ad_si),
        .load_en(1'b0), .load_val('0), .sel('0),
        .q(core_ad), .bit_o(unused_ad_bit)
    );

    ascon_shift_reg #(.W(Y), .SW(CW)) u_din (
        .clk(clk), .rst_n(rst_n),
        .shift_en(in_load && (cnt < CW'(Y))), .sin(data_si),
        .load_en(1'b0), .load_val('0), .sel('0),
        .q(core_din), .bit_o(unused_din_bit)
    );

    ascon_shift_reg #(.W(Y), .SW(CW)) u_dout (
        .clk(clk), .rst_n(rst_n),
        .shift_en(1'b0), .sin(1'b0),
        .load_en(res_load), .load_val(core_dout), .sel(out_sel),
        .q(unused_dout_q), .bit_o(dout_bit)
    );

    ascon_shift_reg #(.W(NONCE_W), .SW(CW)) u_tag (
        .clk(clk), .rst_n(rst_n),
        .shift_en(1'b0), .sin(1'b0),
        .load_en(res_load), .load_val(core_tag), .sel(out_sel),
        .q(unused_tag_q), .bit_o(tag_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            cnt          <= '0;
            start_q      <= 1'b0;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            ready_so     <= 1'b0;
            data_so      <= 1'b0;
            tag_so       <= 1'b0;
        end else begin
            start_q    <= start_si;
            core_start <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (cnt == CW'(MAX - 1)) begin
                        state <= ST_ARMED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ARMED: begin
                    if (start_si && !start_q) begin
                        core_decrypt <= decrypt_si;
                        core_start   <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        ready_so <= 1'b1;
                        state    <= ST_DELAY;
                        cnt      <= '0;
                    end
                end
                ST_DELAY: begin
                    if (cnt == CW'(OUT_DLY - 1)) begin
                        state   <= ST_SHIFT;
                        cnt     <= '0;
                        data_so <= dout_bit;
                        tag_so  <= tag_bit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt == CW'(MAX - 1)) begin
                        state   <= ST_DONE;
                        data_so <= 1'b0;
                        tag_so  <= 1'b0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        data_so <= dout_bit;
                        tag_so  <= tag_bit;
                    end
                end
                ST_DONE: begin
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_serial_if.sv
// Directed bench for ascon_serial_if with a fixed-latency behavioural core model.
module tb_ascon_serial_if;

    localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
    localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;
    localparam logic [127:0] TAG   = 128'hc0ffee0011223344a5a55a5a0f1e2d3c;
    localparam int           DLY   = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_si, nonce_si, ad_si, data_si, start_si, decrypt_si;
    logic         data_so, tag_so, ready_so, core_start, core_decrypt;
    logic [127:0] core_key, core_nonce, core_tag;
    logic [39:0]  core_ad;
    logic [103:0] core_din, core_dout;
    logic         core_done;

    logic         mdl_done = 1'b0;
    logic         tb_done  = 1'b0;
    int           mdl_cnt  = 0;
    int           pulses   = 0;
    int           checks   = 0;
    int           errors   = 0;
    int           base_pulses;

    ascon_serial_if dut (
        .clk(clk), .rst_n(rst_n),
        .key_si(key_si), .nonce_si(nonce_si), .ad_si(ad_si), .data_si(data_si),
        .start_si(start_si), .decrypt_si(decrypt_si),
        .data_so(data_so), .tag_so(tag_so), .ready_so(ready_so),
        .core_start(core_start), .core_decrypt(core_decrypt),
        .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_din(core_din),
        .core_dout(core_dout), .core_tag(core_tag), .core_done(core_done)
    );

    always #5 clk = ~clk;

    // Core stand-in: result is only presented while done is high, so latching is exercised.
    assign core_done = mdl_done | tb_done;
    assign core_dout = core_done ? CT  : '0;
    assign core_tag  = core_done ? TAG : '0;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!rst_n) begin
            mdl_cnt <= 0;
        end else if (core_start) begin
            mdl_cnt <= 20;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (core_start) pulses++;
    end

    task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] n,
                                 input logic [39:0] a, input logic [103:0] d, input int start_at);
        for (int i = 0; i < 128; i++) begin
            key_si   = k[127 - i];
            nonce_si = n[127 - i];
            ad_si    = (i < 40)  ? a[39 - i]  : 1'b0;
            data_si  = (i < 104) ? d[103 - i] : 1'b0;
            if (i == start_at) start_si = 1'b1;
            @(negedge clk);
        end
        key_si = 1'b0; nonce_si = 1'b0; ad_si = 1'b0; data_si = 1'b0;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 60; i++) begin
            if (core_done) break;
            @(negedge clk);
        end
        checkOutput("core_done_seen", {127'b0, core_done}, 128'd1);
        checkOutput("ready_before_done_edge", {127'b0, ready_so}, 128'd0);
        @(negedge clk);
        checkOutput("ready_after_done", {127'b0, ready_so}, 128'd1);
    endtask

    task automatic checkSerial(input int nbits);
        logic [103:0] exp_d;
        logic [127:0] exp_t;
        exp_d = CT;
        exp_t = TAG;
        for (int i = 0; i < nbits; i++) begin
            #1;
            checkOutput($sformatf("data_bit%0d", i), {127'b0, data_so},
                        {127'b0, (i < 104) ? exp_d[i] : 1'b0});
            checkOutput($sformatf("tag_bit%0d", i), {127'b0, tag_so}, {127'b0, exp_t[i]});
            if (i < nbits - 1) @(posedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_si = 1'b0; nonce_si = 1'b0; ad_si = 1'b0; data_si = 1'b0;
        start_si = 1'b0; decrypt_si = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_key", core_key, '0);
        checkOutput("rst_nonce", core_nonce, '0);
        checkOutput("rst_ad", {88'b0, core_ad}, '0);
        checkOutput("rst_din", {24'b0, core_din}, '0);
        checkOutput("rst_outs", {123'b0, data_so, tag_so, ready_so, core_start, core_decrypt}, '0);
        rst_n = 1'b1;

        $display("[TB] encrypt load");
        applyStimulus(KEY, NONCE, AD, PT, -1);
        checkOutput("load_key", core_key, KEY);
        checkOutput("load_nonce", core_nonce, NONCE);
        checkOutput("load_ad", {88'b0, core_ad}, {88'b0, AD});
        checkOutput("load_din", {24'b0, core_din}, {24'b0, PT});
        checkOutput("no_start_in_load", pulses, 0);

        start_si = 1'b1; decrypt_si = 1'b0;
        repeat (2) @(negedge clk);
        start_si = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("single_start_pulse", pulses, 1);
        checkOutput("enc_decrypt_flag", {127'b0, core_decrypt}, '0);

        $display("[TB] encrypt result shift-out");
        waitReady();
        repeat (DLY) @(posedge clk);
        checkSerial(128);
        @(posedge clk);
        #1;
        checkOutput("done_data_zero", {127'b0, data_so}, '0);
        checkOutput("done_tag_zero", {127'b0, tag_so}, '0);
        checkOutput("done_ready_held", {127'b0, ready_so}, 128'd1);
        @(negedge clk);
        start_si = 1'b1;
        repeat (3) @(negedge clk);
        start_si = 1'b0;
        checkOutput("start_ignored_in_done", pulses, 1);
        checkOutput("done_ready_sticky", {127'b0, ready_so}, 128'd1);

        $display("[TB] start edge during load");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base_pulses = pulses;
        applyStimulus(KEY, NONCE, AD, PT, 50);
        repeat (3) @(negedge clk);
        checkOutput("load_start_ignored", pulses, base_pulses);
        checkOutput("load2_din", {24'b0, core_din}, {24'b0, PT});
        checkOutput("load2_key", core_key, KEY);

        $display("[TB] stray core_done while armed");
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("armed_done_ignored", {127'b0, ready_so}, '0);
        start_si = 1'b0;
        @(negedge clk);
        start_si = 1'b1;
        repeat (2) @(negedge clk);
        start_si = 1'b0;
        @(negedge clk);
        checkOutput("still_armed_start", pulses, base_pulses + 1);

        $display("[TB] reset during shift-out");
        waitReady();
        repeat (DLY) @(posedge clk);
        checkSerial(31);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outs", {123'b0, data_so, tag_so, ready_so, core_start, core_decrypt}, '0);
        checkOutput("abort_key", core_key, '0);
        checkOutput("abort_din", {24'b0, core_din}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] decrypt load and start");
        base_pulses = pulses;
        applyStimulus(KEY, NONCE, AD, CT, -1);
        start_si = 1'b1; decrypt_si = 1'b1;
        repeat (2) @(negedge clk);
        start_si = 1'b0; decrypt_si = 1'b0;
        @(negedge clk);
        checkOutput("dec_start_pulse", pulses, base_pulses + 1);
        checkOutput("dec_decrypt_flag", {127'b0, core_decrypt}, 128'd1);
        checkOutput("dec_din", {24'b0, core_din}, {24'b0, CT});
        checkOutput("dec_nonce", core_nonce, NONCE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
